display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl_pkg.sv | 26 ++
 rtl/display_scan_ctrl_if.sv | 31 +++
 rtl/display_scan_ctrl_decoder.sv | 34 +++
 rtl/display_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_pkg                                                        |
// | Shared types and constants for the multiplexed 7-segment scanner.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam int         DIGIT_W = 4;

   // Counter wide enough to reach the longer of the two phase lengths minus one.
   function automatic int cnt_width(input int scan_div, input int blank_cyc);
      int longest;
      longest = (scan_div > blank_cyc) ? scan_div : blank_cyc;
      return (longest <= 2) ? 1 : $clog2(longest);
   endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_scan_ctrl_if                                               |
// | Value/control inputs and display pin outputs of the scanner.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface display_scan_ctrl_if #(
   parameter int N_DIGITS = 4
);
   logic                  enable;
   logic [4*N_DIGITS-1:0] value_in;
   logic                  load;
   logic [N_DIGITS-1:0]   dp_in;
   logic                  blank_lz;
   logic [0:6]            seg_out;
   logic                  dp_out;
   logic [N_DIGITS-1:0]   digit_n;
   logic                  load_pend;
   logic                  frame_done;

   modport master (
      output enable, value_in, load, dp_in, blank_lz,
      input  seg_out, dp_out, digit_n, load_pend, frame_done
   );

   modport slave (
      input  enable, value_in, load, dp_in, blank_lz,
      output seg_out, dp_out, digit_n, load_pend, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/display_scan_ctrl_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | BCD_decoder                                                        |
// | Hex nibble to active-low segments a..g (seg_out[0] = a).           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module BCD_decoder (
   input  logic [3:0] bcd_in,
   output logic [0:6] seg_out
);
   always_comb begin
      seg_out = 7'b1111111;
      case (bcd_in)
         4'h0: seg_out = 7'b0000001;
         4'h1: seg_out = 7'b1001111;
         4'h2: seg_out = 7'b0010010;
         4'h3: seg_out = 7'b0000110;
         4'h4: seg_out = 7'b1001100;
         4'h5: seg_out = 7'b0100100;
         4'h6: seg_out = 7'b0100000;
         4'h7: seg_out = 7'b0001111;
         4'h8: seg_out = 7'b0000000;
         4'h9: seg_out = 7'b0000100;
         4'hA: seg_out = 7'b0001000;
         4'hB: seg_out = 7'b1100000;
         4'hC: seg_out = 7'b0110001;
         4'hD: seg_out = 7'b1000010;
         4'hE: seg_out = 7'b0110000;
         4'hF: seg_out = 7'b0111000;
         default: seg_out = 7'b1111111;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_scan_ctrl                                                  |
// | Round-robin digit scanner with dead-time and tear-free value swap. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic                 clk,
   input  logic                 rst,
   display_scan_ctrl_if.slave   bus
);
   localparam int VAL_W = DIGIT_W * N_DIGITS;
   localparam int CNT_W = cnt_width(SCAN_DIV, BLANK_CYC);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   scan_state_e         state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [VAL_W-1:0]    active_q, active_d;
   logic [VAL_W-1:0]    pending_q, pending_d;
   logic                load_pend_q, load_pend_d;
   logic [0:6]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [N_DIGITS-1:0] digit_n_q, digit_n_d;
   logic                frame_done_q, frame_done_d;

   logic [DIGIT_W-1:0]  nib [N_DIGITS];
   logic [DIGIT_W-1:0]  cur_nib;
   logic [0:6]          dec_seg;
   logic [IDX_W-1:0]    msd_idx;
   logic                swap;

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
      assign nib[g] = active_q[g*DIGIT_W +: DIGIT_W];
   end

   assign cur_nib = nib[idx_q];

   BCD_decoder u_dec (
      .bcd_in  (cur_nib),
      .seg_out (dec_seg)
   );

   // Highest nonzero digit; an all-zero value leaves this at 0 so digit 0 stays lit.
   always_comb begin
      msd_idx = '0;
      for (int i = 1; i < N_DIGITS; i++) begin
         if (nib[i] != '0) msd_idx = IDX_W'(i);
      end
   end

   // The frame boundary: last digit's DRIVE expires while scanning is still enabled.
   assign swap = (state_q == DRIVE) && (cnt_q == DRIVE_LAST) &&
                 (idx_q == IDX_LAST) && bus.enable;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         active_q     <= '0;
         pending_q    <= '0;
         load_pend_q  <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         digit_n_q    <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         load_pend_q  <= load_pend_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         digit_n_q    <= digit_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (!bus.enable) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               idx_d   = '0;
               cnt_d   = '0;
            end
            BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            DRIVE: begin
               if (cnt_q == DRIVE_LAST) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      seg_d        = SEG_OFF;
      dp_d         = 1'b1;
      digit_n_d    = '1;
      frame_done_d = swap;
      if (state_q == DRIVE) begin
         digit_n_d = ~(N_DIGITS'(1) << idx_q);
         seg_d     = (bus.blank_lz && (idx_q > msd_idx)) ? SEG_OFF : dec_seg;
         dp_d      = ~bus.dp_in[idx_q];
      end
   end

   // A load landing on the swap edge bypasses the pending buffer.
   always_comb begin
      pending_d   = bus.load ? bus.value_in : pending_q;
      active_d    = active_q;
      load_pend_d = bus.load ? 1'b1 : load_pend_q;
      if (swap) begin
         active_d    = bus.load ? bus.value_in : pending_q;
         load_pend_d = 1'b0;
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.dp_out     = dp_q;
   assign bus.digit_n    = digit_n_q;
   assign bus.load_pend  = load_pend_q;
   assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_display_scan_ctrl                                               |
// | Scoreboard bench: expected digit drives queued, monitor compares. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_display_scan_ctrl;

   localparam logic [6:0] G0  = 7'b0000001;
   localparam logic [6:0] G1  = 7'b1001111;
   localparam logic [6:0] G2  = 7'b0010010;
   localparam logic [6:0] G3  = 7'b0000110;
   localparam logic [6:0] G4  = 7'b1001100;
   localparam logic [6:0] G5  = 7'b0100100;
   localparam logic [6:0] GA  = 7'b0001000;
   localparam logic [6:0] GB  = 7'b1100000;
   localparam logic [6:0] GC  = 7'b0110001;
   localparam logic [6:0] GD  = 7'b1000010;
   localparam logic [6:0] GF  = 7'b0111000;
   localparam logic [6:0] OFF = 7'b1111111;

   typedef struct {
      logic [3:0] dn;
      logic [6:0] seg;
      logic       dp;
      int         len;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   cyc_f1, cyc_f2;
   bit   mon_en = 1'b0;
   bit   on_prev = 1'b0;
   bit   have = 1'b0;
   int   run = 0;
   exp_t cur;
   exp_t exp_q[$];

   display_scan_ctrl_if #(.N_DIGITS(4)) bus ();

   display_scan_ctrl #(
      .N_DIGITS  (4),
      .SCAN_DIV  (4),
      .BLANK_CYC (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_digit(input int i, input logic [6:0] seg, input logic dp, input int len);
      exp_t e;
      e.dn  = ~(4'b0001 << i);
      e.seg = seg;
      e.dp  = dp;
      e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dp);
      push_digit(0, s0, ~dp[0], 4);
      push_digit(1, s1, ~dp[1], 4);
      push_digit(2, s2, ~dp[2], 4);
      push_digit(3, s3, ~dp[3], 4);
   endtask

   task automatic wait_fd();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.frame_done && n < 80);
      check("frame_done_seen", 32'(bus.frame_done), 32'd1);
   endtask

   task automatic check_dark(input string name);
      check({name, "_seg"},     32'(bus.seg_out),    32'h7F);
      check({name, "_digit_n"}, 32'(bus.digit_n),    32'hF);
      check({name, "_dp"},      32'(bus.dp_out),     32'd1);
      check({name, "_fdone"},   32'(bus.frame_done), 32'd0);
   endtask

   // Monitor: each contiguous drive window pops one expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && bus.digit_n !== 4'hF) begin
            if (!on_prev) begin
               run = 0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  have = 1'b0;
                  $display("FAIL unexpected_drive: got digit_n %b, required no drive", bus.digit_n);
               end else begin
                  cur  = exp_q.pop_front();
                  have = 1'b1;
               end
            end
            if (have) begin
               check("drive_digit_n", 32'(bus.digit_n), 32'(cur.dn));
               check("drive_seg",     32'(bus.seg_out), 32'(cur.seg));
               check("drive_dp",      32'(bus.dp_out),  32'(cur.dp));
            end
            run++;
            on_prev = 1'b1;
         end else begin
            if (on_prev && have) check("drive_len", 32'(run), 32'(cur.len));
            on_prev = 1'b0;
         end
      end
   end

   initial begin
      bus.enable   = 1'b1;
      bus.load     = 1'b1;
      bus.value_in = 16'hFFFF;
      bus.dp_in    = 4'b0000;
      bus.blank_lz = 1'b0;

      // Reset with enable and load asserted
      repeat (3) tick();
      check_dark("reset");
      check("reset_load_pend", 32'(bus.load_pend), 32'd0);
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.load   = 1'b0;
      tick();
      check("post_reset_load_pend", 32'(bus.load_pend), 32'd0);

      // Load 1234 while idle; first frame still shows the reset value
      bus.load = 1'b1;
      bus.value_in = 16'h1234;
      tick();
      bus.load = 1'b0;
      check("load_pend_idle", 32'(bus.load_pend), 32'd1);
      push_frame(G0, G0, G0, G0, 4'b0000);
      push_frame(G4, G3, G2, G1, 4'b0000);
      mon_en = 1'b1;
      bus.enable = 1'b1;
      wait_fd();
      cyc_f1 = cyc;
      check("swap1_load_pend", 32'(bus.load_pend), 32'd0);

      // Tear-free: load ABCD during digit 1 of the 1234 frame
      repeat (9) @(posedge clk);
      #1;
      bus.load = 1'b1;
      bus.value_in = 16'hABCD;
      tick();
      bus.load = 1'b0;
      check("tearfree_load_pend", 32'(bus.load_pend), 32'd1);
      push_frame(GD, GC, GB, GA, 4'b0000);
      wait_fd();
      cyc_f2 = cyc;
      check("frame_period", 32'(cyc_f2 - cyc_f1), 32'd24);
      check("swap2_load_pend", 32'(bus.load_pend), 32'd0);

      // Coincident load on the swap edge
      push_frame(G0, GF, G0, G0, 4'b0000);
      repeat (23) @(posedge clk);
      #1;
      bus.load = 1'b1;
      bus.value_in = 16'h00F0;
      tick();
      bus.load = 1'b0;
      check("coincident_frame_done", 32'(bus.frame_done), 32'd1);
      check("coincident_load_pend", 32'(bus.load_pend), 32'd0);
      repeat (5) tick();
      check("coincident_load_pend_later", 32'(bus.load_pend), 32'd0);

      // Leading-zero suppression with a decimal point on digit 0
      bus.load = 1'b1;
      bus.value_in = 16'h0050;
      tick();
      bus.load = 1'b0;
      check("lz_load_pend", 32'(bus.load_pend), 32'd1);
      push_frame(G0, G5, OFF, OFF, 4'b0001);
      wait_fd();
      check("swap4_load_pend", 32'(bus.load_pend), 32'd0);
      bus.blank_lz = 1'b1;
      bus.dp_in    = 4'b0001;
      push_digit(0, G0, 1'b0, 4);
      push_digit(1, G5, 1'b1, 4);
      push_digit(2, OFF, 1'b1, 2);
      wait_fd();

      // Abort during DRIVE of digit 2
      repeat (15) @(posedge clk);
      #1;
      bus.enable = 1'b0;
      tick();
      check("abort_lag_digit_n", 32'(bus.digit_n), 32'hB);
      tick();
      check_dark("abort_off");
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle_frame_done", 32'(bus.frame_done), 32'd0);
      end

      // Restart: digit 0 after two blank cycles, then reset mid-scan
      push_digit(0, G0, 1'b0, 1);
      bus.enable = 1'b1;
      tick();
      bus.load = 1'b1;
      bus.value_in = 16'h1111;
      tick();
      bus.load = 1'b0;
      tick();
      check("restart_blank_digit_n", 32'(bus.digit_n), 32'hF);
      check("restart_load_pend", 32'(bus.load_pend), 32'd1);
      tick();
      check("restart_digit0", 32'(bus.digit_n), 32'hE);
      rst = 1'b0;
      tick();
      check_dark("midscan_reset");
      check("midscan_reset_load_pend", 32'(bus.load_pend), 32'd0);
      bus.enable = 1'b0;
      rst = 1'b1;
      repeat (5) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
